// File: rtl/com_to_in.sv
// ----------------------------------------------------------------------------
// com_to_in : oversampling serial receiver.
//
// Decodes frames of the form: start bit (0), eight data bits LSB first,
// an even-parity bit and a stop bit (1). The line idles high. The `rx`
// line is resynchronised, sampled at mid-bit on the `enable` tick strobe,
// and every completed frame is delivered with a one-clock `isReady` pulse.
// Errored frames are still delivered, with parityErr/frameErr flagged.
//
// Ports:
//   clk        in   clock, all registers update on its rising edge
//   resetN     in   asynchronous active-low reset
//   enable     in   one-clk sample tick at OVERSAMPLE x bit rate
//   rx         in   asynchronous serial line
//   data       out  [7:0] last received byte, held until the next frame
//   isReady    out  one-clk pulse: data/parityErr/frameErr just updated
//   parityErr  out  last frame failed the even-parity check
//   frameErr   out  last frame's stop bit sampled 0
//
// Handshake: isReady is a pure valid strobe with no ready back-pressure;
// data, parityErr and frameErr change only on the edge that raises it.
// ----------------------------------------------------------------------------
module com_to_in #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       isReady,
  output logic       parityErr,
  output logic       frameErr
);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("com_to_in: OVERSAMPLE must be even and at least 4");
  end

  localparam int CNT_W = $clog2(OVERSAMPLE);

  // Counter value seen on the start-bit check tick: IDLE already counted
  // tick 1 by loading 1, so tick OVERSAMPLE/2 arrives with OVERSAMPLE/2-1.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Two-flop synchroniser; both flops reset high to match an idle line.
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [7:0]       data_q;
  logic             ready_q;
  logic             perr_q;
  logic             ferr_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      // The strobe lasts one clk whether or not the next cycle is a tick.
      ready_q <= 1'b0;
      if (enable) begin
        case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              state_q <= START;
              cnt_q   <= ONE;
            end
          end

          START: begin
            if (cnt_q == HALF_M1) begin
              cnt_q <= '0;
              bit_q <= 3'd0;
              // A high line at mid start bit was a glitch, not a frame.
              state_q <= rx_s_q ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end

          DATA: begin
            if (cnt_q == LAST) begin
              cnt_q          <= '0;
              shift_q[bit_q] <= rx_s_q;
              bit_q          <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_q <= PARITY;
              end
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end

          PARITY: begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              par_q   <= rx_s_q;
              state_q <= STOP;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end

          STOP: begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              data_q  <= shift_q;
              perr_q  <= (^shift_q) ^ par_q;
              ferr_q  <= ~rx_s_q;
              ready_q <= 1'b1;
              // Leaving via BREAK keeps a held-low line from looking like
              // a stream of back-to-back start bits.
              state_q <= rx_s_q ? IDLE : BREAK;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end

          BREAK: begin
            if (rx_s_q) begin
              state_q <= IDLE;
            end
          end

          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign data      = data_q;
  assign isReady   = ready_q;
  assign parityErr = perr_q;
  assign frameErr  = ferr_q;

endmodule

// File: tb/tb_com_to_in.sv
// ----------------------------------------------------------------------------
// tb_com_to_in : directed bench for com_to_in (OVERSAMPLE = 16, one tick
// every 4 clk). The driver shapes frames at tick granularity and pushes the
// hand-computed response plus the tick on which it must appear; a separate
// monitor pops and compares on every isReady pulse.
// ----------------------------------------------------------------------------
module tb_com_to_in;

  localparam int OS = 16;

  logic       clk;
  logic       resetN;
  logic       enable;
  logic       rx;
  logic [7:0] data;
  logic       isReady;
  logic       parityErr;
  logic       frameErr;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  int en_div = 0;

  // {parityErr, frameErr, data}
  logic [9:0] exp_q[$];
  int         tick_q[$];

  com_to_in #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .enable    (enable),
    .rx        (rx),
    .data      (data),
    .isReady   (isReady),
    .parityErr (parityErr),
    .frameErr  (frameErr)
  );

  // ---------------- clock / reset / tick generation ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      en_div = (en_div + 1) % 4;
      enable = (en_div == 0);
    end
  end

  always @(posedge clk) begin
    if (enable === 1'b1) tick_cnt = tick_cnt + 1;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns 2 time units after the clk edge of the next tick.
  task automatic wait_tick();
    do @(posedge clk); while (enable !== 1'b1);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // Sends one frame starting right after the current tick; the stop sample
  // lands on the frame's tick 168 = start tick + 167.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic [7:0] exp_data, input logic exp_perr,
                            input logic exp_ferr);
    int start;
    start = tick_cnt + 1;
    exp_q.push_back({exp_perr, exp_ferr, exp_data});
    tick_q.push_back(start + 167);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    rx = par;
    wait_ticks(OS);
    rx = stop;
    wait_ticks(OS);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [9:0] e;
    int         t;
    forever begin
      @(posedge clk);
      #1;
      if (isReady === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: data=%0h perr=%0b ferr=%0b, no frame expected (t=%0t)",
                   data, parityErr, frameErr, $time);
        end else begin
          e = exp_q.pop_front();
          t = tick_q.pop_front();
          check("data", 32'(data), 32'(e[7:0]));
          check("parityErr", 32'(parityErr), 32'(e[9]));
          check("frameErr", 32'(frameErr), 32'(e[8]));
          check("ready_tick", 32'(tick_cnt), 32'(t));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rx     = 1'b1;
    resetN = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", 32'(data), 32'h00);
    check("reset_ready", 32'(isReady), 32'h0);
    check("reset_perr", 32'(parityErr), 32'h0);
    check("reset_ferr", 32'(frameErr), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    wait_tick();
    idle_ticks(4);

    // Clean byte, ready on tick 168.
    send_frame(8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle_ticks(6);

    // Parity error: 0x01 has odd weight, parity bit sent as 0.
    send_frame(8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    idle_ticks(6);

    // Glitch: low for 5 ticks, gone before the mid start-bit check.
    rx = 1'b0;
    wait_ticks(5);
    idle_ticks(20);
    send_frame(8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    idle_ticks(6);

    // Break: stop bit low, line held low 40 more ticks.
    send_frame(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    rx = 1'b0;
    wait_ticks(40);
    idle_ticks(20);
    send_frame(8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    idle_ticks(6);

    // Back-to-back frames with no idle gap (0x80 has odd weight -> parity 1).
    send_frame(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
    idle_ticks(6);

    // Reset after data bit 3 of 0x96; no frame pushed for it.
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h96 >> i) & 8'h01;
      wait_ticks(OS);
    end
    resetN = 1'b0;
    rx     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_ready", 32'(isReady), 32'h0);
    check("midreset_perr", 32'(parityErr), 32'h0);
    check("midreset_ferr", 32'(frameErr), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    wait_tick();
    idle_ticks(5);
    send_frame(8'h69, 1'b0, 1'b1, 8'h69, 1'b0, 1'b0);
    idle_ticks(10);

    check("pending_frames", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/com_to_in.md
# com_to_in

Serial receiver for the board's UART-style link. It decodes the frame format our serial transmitter produces: a start bit (0), eight data bits LSB first, an even-parity bit and a stop bit (1), with the line idling high. It oversamples the `rx` line on a tick strobe, validates the start bit, stop bit and parity, and presents each received byte with a one-clock `isReady` pulse to the downstream logic.

## Interface
- `OVERSAMPLE`, default 16: sample ticks per bit period. Must be even and at least 4; any other value is an elaboration error.
- `clk` input 1: the only clock; every register updates on its rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `enable` input 1: sample tick, one `clk` wide, at `OVERSAMPLE` times the bit rate. The state machine advances only on cycles where `enable` is high.
- `rx` input 1: asynchronous serial line.
- `data` output 8: last received byte; held until the next frame completes.
- `isReady` output 1: one-`clk` pulse marking that `data`, `parityErr` and `frameErr` were just updated.
- `parityErr` output 1: high when the last frame failed the even-parity check.
- `frameErr` output 1: high when the last frame's stop bit sampled 0.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser to give `rxS`. Both flops reset to 1. All decisions use `rxS`.
- **Registers:**
  - state: IDLE, START, DATA, PARITY, STOP, BREAK.
  - tick counter: width $clog2(OVERSAMPLE).
  - bit index: 3 bits.
  - shift register: 8 bits.
  - parity-bit capture: 1 bit.
- **Tick counting:** in this section, "tick n" means the nth `enable` cycle. The cycle on which IDLE sees `rxS`=0 is tick 1.
- **IDLE:** on a tick with `rxS`=0, go to START with the counter set to 1.
- **START:** each tick increments the counter. At tick OVERSAMPLE/2 (mid start bit):
  - `rxS`=0: go to DATA with counter 0 and bit index 0.
  - `rxS`=1: false start; return to IDLE. No outputs change.
- **DATA:** a sample is taken every OVERSAMPLE ticks, i.e. when the counter reaches OVERSAMPLE-1. The counter then wraps to 0.
  - `rxS` is stored into `shift[bitIndex]`.
  - After bit 7, go to PARITY.
- **PARITY:** the same counting rule applies; `rxS` is captured as the parity bit, then go to STOP.
- **STOP:** the same counting rule applies. On the sampling tick, update all outputs together:
  - `data` <= shift.
  - `parityErr` <= XOR of the 8 shift bits XOR the parity bit.
  - `frameErr` <= !`rxS`.
  - `isReady` <= 1.
  - Next state is IDLE if `rxS`=1, or BREAK if `rxS`=0.
- **BREAK:** stay until a tick sees `rxS`=1, then go to IDLE. This stops a held-low line from being taken as back-to-back frames.
- **Errored frames:** frames with parity or framing errors are still delivered. `data` is updated and `isReady` pulses.
- **`enable` low:** all state, counters and the shift register hold. `isReady` still clears after one `clk`.

## Timing
- **Reset values:** while `resetN`=0:
  - `data`=8'h00, `isReady`=0, `parityErr`=0, `frameErr`=0.
  - State IDLE, counter 0, bit index 0, shift 0, synchroniser flops 1.
- **Reset mid-frame:** discards the partial frame with no `isReady`. Reception restarts on the first low `rxS` seen after reset is released.
- **Input latency:** 2 `clk` cycles from an `rx` edge to the change on `rxS`.
- **Sample points, counted from tick 1:**
  - Start-bit check at tick OVERSAMPLE/2.
  - Data bit k at tick OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - Parity bit at tick OVERSAMPLE/2 + 9·OVERSAMPLE.
  - Stop bit at tick OVERSAMPLE/2 + 10·OVERSAMPLE (tick 168 for OVERSAMPLE=16).
- **`isReady`:** goes high on the `clk` edge of the stop-sample tick, and low on the next `clk` edge regardless of `enable`.
- **Back-to-back frames:** a new frame's start bit may begin immediately after the stop bit. IDLE is re-entered on the stop-sample tick, so the next falling edge is detected within one tick.
- **Same-cycle updates:** the outputs update on the same edge as `isReady` is raised. A `parityErr` or `frameErr` from an earlier frame is overwritten, not held sticky.

## Test plan
- **Clean byte:** OVERSAMPLE=16, `enable` every 4 `clk`, frame 0xA5 with parity 0 and stop 1 -> one `isReady` pulse, `data`=0xA5, `parityErr`=0, `frameErr`=0, pulse on tick 168.
- **Parity error:** frame 0x01 sent with parity bit 0 -> `data`=0x01, `parityErr`=1, `frameErr`=0, `isReady` pulses once.
- **Glitch rejection:** `rx` low for 5 ticks, then high -> returns to IDLE, no `isReady`. A following valid frame 0x3C is then received correctly.
- **Break / framing error:** frame 0xFF with stop bit 0, then `rx` held low for 40 ticks, then high -> exactly one `isReady` with `frameErr`=1. No further frames until `rx` returns high, and the next frame 0x55 decodes with `frameErr`=0.
- **Back-to-back frames:** transmitter frames 0x00, 0x80 and 0x7E sent with no idle gap -> three `isReady` pulses in order with matching `data` values and no errors.
- **Reset mid-frame:** `resetN` pulsed low after data bit 3 of frame 0x96 -> all outputs are at their reset values, no `isReady` for that frame, and the next frame 0x69 is received correctly.
